prco_pipe_ctrl: RTL

PRCO_PIPE_CTRL -- requirements
Module: prco_pipe_ctrl

---
 rtl/prco_pipe_if.sv | 35 +++
 rtl/prco_pipe_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/prco_pipe_if.sv
// Handshake and memory bus between the pipeline controller and its datapath
// (memory, decoder, register file, ALU).
interface prco_pipe_if #(
   parameter int PC_W = 16
);
   logic [PC_W-1:0] q_mem_addr;
   logic            q_mem_re;
   logic            q_mem_we;
   logic            q_dec_ce;
   logic            i_dec_done;
   logic            i_dec_req_ram;
   logic            i_dec_ram_we;
   logic            i_dec_reg_we;
   logic            q_reg_ce;
   logic            q_alu_ce;
   logic            i_alu_done;
   logic            i_alu_branch;
   logic [PC_W-1:0] i_alu_result;
   logic            q_reg_we;
   logic            q_wb_sel_mem;

   modport master (
      output q_mem_addr, q_mem_re, q_mem_we, q_dec_ce, q_reg_ce, q_alu_ce,
             q_reg_we, q_wb_sel_mem,
      input  i_dec_done, i_dec_req_ram, i_dec_ram_we, i_dec_reg_we,
             i_alu_done, i_alu_branch, i_alu_result
   );

   modport slave (
      input  q_mem_addr, q_mem_re, q_mem_we, q_dec_ce, q_reg_ce, q_alu_ce,
             q_reg_we, q_wb_sel_mem,
      output i_dec_done, i_dec_req_ram, i_dec_ram_we, i_dec_reg_we,
             i_alu_done, i_alu_branch, i_alu_result
   );
endinterface

// File: rtl/prco_pipe_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, register read, ALU,
// optional memory access and writeback, with per-stage timeout to a halt state.
//
// state   | meaning
// S_FETCH | idle until i_en, then issue instruction read
// S_FWAIT | instruction memory latency (MEM_LAT cycles)
// S_DEC   | wait for decoder done (timed)
// S_REG   | register-file read, one cycle
// S_ALU   | wait for ALU done (timed)
// S_MEM   | data load (MEM_LAT cycles) or store (one cycle)
// S_WB    | writeback, retire, PC update
// S_HALT  | stage timeout; frozen until reset
module prco_pipe_ctrl #(
   parameter int PC_W      = 16,
   parameter int RESET_VEC = 0,
   parameter int WRAP_EN   = 1,
   parameter int PC_LIMIT  = 7,
   parameter int MEM_LAT   = 1,
   parameter int TMO       = 16,
   parameter int CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   prco_pipe_if.master      bus,
   output logic [PC_W-1:0]  q_pc,
   output logic             q_retire,
   output logic [CNT_W-1:0] q_retired_cnt,
   output logic             q_fault,
   output logic [2:0]       q_state
);
   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_FWAIT = 3'd1,
      S_DEC   = 3'd2,
      S_REG   = 3'd3,
      S_ALU   = 3'd4,
      S_MEM   = 3'd5,
      S_WB    = 3'd6,
      S_HALT  = 3'd7
   } state_t;

   localparam logic [7:0]      LAT_LD  = 8'(MEM_LAT - 1);
   localparam logic [7:0]      TMO_LD  = 8'(TMO - 1);
   localparam logic [PC_W-1:0] RST_PC  = PC_W'(RESET_VEC);
   localparam logic [PC_W-1:0] LIM_PC  = PC_W'(PC_LIMIT);

   state_t           state_q, state_d;
   logic [7:0]       tmr_q, tmr_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_q, fault_d;
   logic             req_ram_q, req_ram_d;
   logic             ram_we_q, ram_we_d;
   logic             att_reg_we_q, att_reg_we_d;
   logic             branch_q, branch_d;
   logic [PC_W-1:0]  res_q, res_d;
   logic             mem_re_q, mem_re_d;
   logic             mem_we_q, mem_we_d;
   logic             dec_ce_q, dec_ce_d;
   logic             reg_ce_q, reg_ce_d;
   logic             alu_ce_q, alu_ce_d;
   logic             reg_we_q, reg_we_d;
   logic             wb_sel_q, wb_sel_d;
   logic             retire_q, retire_d;

   always_comb begin
      state_d      = state_q;
      tmr_d        = tmr_q;
      pc_d         = pc_q;
      cnt_d        = cnt_q;
      fault_d      = fault_q;
      req_ram_d    = req_ram_q;
      ram_we_d     = ram_we_q;
      att_reg_we_d = att_reg_we_q;
      branch_d     = branch_q;
      res_d        = res_q;
      mem_re_d     = 1'b0;
      mem_we_d     = 1'b0;
      dec_ce_d     = 1'b0;
      reg_ce_d     = 1'b0;
      alu_ce_d     = 1'b0;
      reg_we_d     = 1'b0;
      wb_sel_d     = 1'b0;
      retire_d     = 1'b0;

      case (state_q)
         S_FETCH: begin
            if (i_en) begin
               mem_re_d = 1'b1;
               tmr_d    = LAT_LD;
               state_d  = S_FWAIT;
            end
         end
         S_FWAIT: begin
            if (tmr_q == 8'd0) begin
               dec_ce_d = 1'b1;
               tmr_d    = TMO_LD;
               state_d  = S_DEC;
            end else begin
               tmr_d = tmr_q - 8'd1;
            end
         end
         S_DEC: begin
            // done is checked before the timeout so a late done still counts
            if (bus.i_dec_done) begin
               req_ram_d    = bus.i_dec_req_ram;
               ram_we_d     = bus.i_dec_ram_we;
               att_reg_we_d = bus.i_dec_reg_we;
               reg_ce_d     = 1'b1;
               state_d      = S_REG;
            end else if (tmr_q == 8'd0) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               tmr_d = tmr_q - 8'd1;
            end
         end
         S_REG: begin
            alu_ce_d = 1'b1;
            tmr_d    = TMO_LD;
            state_d  = S_ALU;
         end
         S_ALU: begin
            if (bus.i_alu_done) begin
               branch_d = bus.i_alu_branch;
               res_d    = bus.i_alu_result;
               if (req_ram_q) begin
                  mem_we_d = ram_we_q;
                  mem_re_d = ~ram_we_q;
                  tmr_d    = LAT_LD;
                  state_d  = S_MEM;
               end else begin
                  state_d = S_WB;
               end
            end else if (tmr_q == 8'd0) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               tmr_d = tmr_q - 8'd1;
            end
         end
         S_MEM: begin
            if (ram_we_q || tmr_q == 8'd0) begin
               state_d = S_WB;
            end else begin
               tmr_d = tmr_q - 8'd1;
            end
         end
         S_WB: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_FETCH;
            if (branch_q) begin
               pc_d = res_q;
            end else if ((WRAP_EN != 0) && (pc_q >= LIM_PC)) begin
               pc_d = RST_PC;
            end else begin
               pc_d = pc_q + 1'b1;
            end
         end
         default: ;
      endcase

      // writeback strobes are registered so they line up with the S_WB cycle
      if (state_d == S_WB) begin
         reg_we_d = att_reg_we_q & ~(req_ram_q & ram_we_q);
         wb_sel_d = req_ram_q & ~ram_we_q;
         retire_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= S_FETCH;
         tmr_q        <= 8'd0;
         pc_q         <= RST_PC;
         cnt_q        <= '0;
         fault_q      <= 1'b0;
         req_ram_q    <= 1'b0;
         ram_we_q     <= 1'b0;
         att_reg_we_q <= 1'b0;
         branch_q     <= 1'b0;
         res_q        <= '0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         dec_ce_q     <= 1'b0;
         reg_ce_q     <= 1'b0;
         alu_ce_q     <= 1'b0;
         reg_we_q     <= 1'b0;
         wb_sel_q     <= 1'b0;
         retire_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         pc_q         <= pc_d;
         cnt_q        <= cnt_d;
         fault_q      <= fault_d;
         req_ram_q    <= req_ram_d;
         ram_we_q     <= ram_we_d;
         att_reg_we_q <= att_reg_we_d;
         branch_q     <= branch_d;
         res_q        <= res_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         dec_ce_q     <= dec_ce_d;
         reg_ce_q     <= reg_ce_d;
         alu_ce_q     <= alu_ce_d;
         reg_we_q     <= reg_we_d;
         wb_sel_q     <= wb_sel_d;
         retire_q     <= retire_d;
      end
   end

   assign bus.q_mem_addr   = (state_q == S_MEM) ? res_q : pc_q;
   assign bus.q_mem_re     = mem_re_q;
   assign bus.q_mem_we     = mem_we_q;
   assign bus.q_dec_ce     = dec_ce_q;
   assign bus.q_reg_ce     = reg_ce_q;
   assign bus.q_alu_ce     = alu_ce_q;
   assign bus.q_reg_we     = reg_we_q;
   assign bus.q_wb_sel_mem = wb_sel_q;

   assign q_pc          = pc_q;
   assign q_retire      = retire_q;
   assign q_retired_cnt = cnt_q;
   assign q_fault       = fault_q;
   assign q_state       = state_q;
endmodule
